spi_flash_reader: RTL and testbench

//  Upstream of the game loader: turns {rd_en, addr} into SPI NOR read transactions and returns 4 bytes per request.
//  - dout is returned with a one-cycle ready strobe.
//  - Connects directly: flash_address->addr, loading->rd_en, dout->flash_dout, ready->flashmem_ready.
//  - One transaction per address; CS released between reads.

---
 rtl/spi_flash_reader.sv | 162 ++++++++++++++++
 tb/tb_spi_flash_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_reader
// Description : SPI NOR reader, one 4-byte little-endian read per request.
//               Option macro SPI_FLASH_FAST_READ_EN: 0x0B + 8 dummy clocks.
// Revision    : 1.0
// ============================================================================
module spi_flash_reader #(
   parameter int CLK_DIV = 1,
   parameter int CS_GAP  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd_en,
   input  logic [23:0] addr,
   output logic [31:0] dout,
   output logic        ready,
   output logic        busy,
   output logic        spi_csn,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [DW-1:0] c_div_last = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] c_gap_last = GW'(CS_GAP - 1);
`ifdef SPI_FLASH_FAST_READ_EN
   localparam logic [7:0] c_cmd = 8'h0B;
`else
   localparam logic [7:0] c_cmd = 8'h03;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE, S_GAP
   } state_t;

   state_t          state_q;
   logic [DW-1:0]   div_q;
   logic [GW-1:0]   gap_q;
   logic [5:0]      bit_cnt_q;
   logic [30:0]     shift_q;
   logic [6:0]      byte_q;
   logic [23:0]     data_q;
   logic [31:0]     dout_q;
   logic            ready_q;
   logic            busy_q;
   logic            csn_q;
   logic            sck_q;
   logic            mosi_q;

   logic            w_half_end;
   logic            w_bit_last;
   logic [7:0]      w_rx_byte;

   assign w_half_end = (div_q == c_div_last);
   assign w_rx_byte  = {byte_q, spi_miso};

   always_comb begin
      w_bit_last = 1'b0;
      case (state_q)
         S_CMD:   w_bit_last = (bit_cnt_q == 6'd7);
         S_ADDR:  w_bit_last = (bit_cnt_q == 6'd23);
         S_DUMMY: w_bit_last = (bit_cnt_q == 6'd7);
         S_DATA:  w_bit_last = (bit_cnt_q == 6'd31);
         default: w_bit_last = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         gap_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         byte_q    <= '0;
         data_q    <= '0;
         dout_q    <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         csn_q     <= 1'b1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (rd_en) begin
                  state_q   <= S_CMD;
                  busy_q    <= 1'b1;
                  csn_q     <= 1'b0;
                  sck_q     <= 1'b0;
                  div_q     <= '0;
                  bit_cnt_q <= '0;
                  shift_q   <= {c_cmd[6:0], addr};
                  mosi_q    <= c_cmd[7];
               end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
               div_q <= w_half_end ? '0 : div_q + 1'b1;
               if (w_half_end && !sck_q) begin
                  sck_q <= 1'b1;
               end else if (w_half_end) begin
                  // End of the high phase: sample miso, fall sck, present next bit.
                  sck_q     <= 1'b0;
                  mosi_q    <= shift_q[30];
                  shift_q   <= {shift_q[29:0], 1'b0};
                  bit_cnt_q <= w_bit_last ? 6'd0 : bit_cnt_q + 6'd1;
                  if (state_q == S_DATA) begin
                     byte_q <= w_rx_byte[6:0];
                     if (bit_cnt_q[2:0] == 3'd7)
                        data_q <= {w_rx_byte, data_q[23:8]};
                  end
                  if (w_bit_last) begin
                     if (state_q == S_CMD) begin
                        state_q <= S_ADDR;
                     end else if (state_q == S_ADDR) begin
                        mosi_q <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
                        state_q <= S_DUMMY;
`else
                        state_q <= S_DATA;
`endif
                     end else if (state_q == S_DUMMY) begin
                        state_q <= S_DATA;
                     end else begin
                        state_q <= S_DONE;
                        csn_q   <= 1'b1;
                        ready_q <= 1'b1;
                        dout_q  <= {w_rx_byte, data_q};
                     end
                  end
               end
            end
            S_DONE: begin
               state_q <= S_GAP;
               gap_q   <= '0;
            end
            S_GAP: begin
               if (gap_q == c_gap_last) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dout     = dout_q;
   assign ready    = ready_q;
   assign busy     = busy_q;
   assign spi_csn  = csn_q;
   assign spi_sck  = sck_q;
   assign spi_mosi = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_reader
// Description : Random-address reads against a behavioural SPI NOR model.
// Revision    : 1.0
// ============================================================================
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FAST_READ_EN
   localparam int         CLK_DIV = 2;
   localparam int         NB      = 72;
   localparam int         HDR     = 40;
   localparam logic [7:0] CMD     = 8'h0B;
`else
   localparam int         CLK_DIV = 1;
   localparam int         NB      = 64;
   localparam int         HDR     = 32;
   localparam logic [7:0] CMD     = 8'h03;
`endif
   localparam int CS_GAP = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rd_en = 1'b0;
   logic [23:0] addr = '0;
   logic [31:0] dout;
   logic        ready, busy, spi_csn, spi_sck, spi_mosi;
   logic        spi_miso = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int hi_run = 0;
   int last_hi_run = 0;

   spi_flash_reader #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .addr(addr),
      .dout(dout), .ready(ready), .busy(busy),
      .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   // Flash contents: fixed bytes at 0x200000.., a hash elsewhere.
   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      if (a[23:2] == 22'h080000)
         return 8'h11 * ({6'b0, a[1:0]} + 8'd1);
      return a[7:0] ^ a[15:8] ^ {a[22:16], a[23]} ^ 8'hA5;
   endfunction

   function automatic logic [31:0] ref_word(input logic [23:0] a);
      return {mem_byte(a + 24'd3), mem_byte(a + 24'd2), mem_byte(a + 24'd1), mem_byte(a)};
   endfunction

   // SPI NOR device model (mode 0)
   int          f_start = 0;
   int          f_seen = 0;
   int          f_cnt = 0;
   int          f_dummy_bad = 0;
   logic [31:0] f_hdr = '0;
   int          fj;
   logic [7:0]  fb;

   always @(negedge spi_csn) f_start = f_start + 1;

   always @(posedge spi_sck) begin
      if (spi_csn === 1'b0) begin
         if (f_seen != f_start) begin
            f_seen = f_start;
            f_cnt  = 0;
            f_hdr  = '0;
         end
         if (f_cnt < 32) f_hdr = {f_hdr[30:0], spi_mosi};
         else if (f_cnt < HDR && spi_mosi !== 1'b0) f_dummy_bad = f_dummy_bad + 1;
         f_cnt = f_cnt + 1;
      end
   end

   always @(negedge spi_sck) begin
      if (spi_csn === 1'b0) begin
         if (f_cnt >= HDR && f_cnt < HDR + 32) begin
            fj = f_cnt - HDR;
            fb = mem_byte(f_hdr[23:0] + 24'(fj / 8));
            spi_miso = fb[7 - (fj % 8)];
         end else begin
            spi_miso = 1'($urandom_range(0, 1));
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (spi_csn === 1'b1) hi_run++;
      else begin
         if (hi_run > 0) last_hi_run = hi_run;
         hi_run = 0;
      end
   endtask

   task automatic run_txn(input logic [23:0] a, input bit fresh, input bit hold,
                          input bit poke, input logic [23:0] next_a);
      int t_set, t1, rdy, budget;
      logic [31:0] exp_d;
      exp_d = ref_word(a);
      if (fresh) repeat (CS_GAP + 1 + $urandom_range(0, 3)) step();
      addr   = a;
      rd_en  = 1'b1;
      t_set  = cyc;
      t1     = -1;
      rdy    = -1;
      budget = 2 * CLK_DIV * NB + 2 * CS_GAP + 20;
      for (int i = 0; i < budget && rdy < 0; i++) begin
         step();
         if (t1 < 0 && spi_csn === 1'b0) begin
            t1 = cyc;
            if (!hold) rd_en = 1'b0;
         end
         if (poke && t1 >= 0 && cyc == t1 + HDR * 2 * CLK_DIV + 3) addr = 24'hABCDEF;
         if (ready === 1'b1) rdy = cyc;
      end
      if (rdy < 0 || t1 < 0) begin
         check("timeout", 32'd0, 32'd1);
         rd_en = 1'b0;
         return;
      end
      if (fresh) check("accept_t1", t1, t_set + 1);
      else       check("csn_gap", last_hi_run, CS_GAP + 2);
      check("latency", rdy - t1, 2 * CLK_DIV * NB);
      check("dout", dout, exp_d);
      check("cmd_addr", f_hdr, {CMD, a});
      check("sck_count", f_cnt, NB);
      check("csn_done", {31'b0, spi_csn}, 32'd1);
      check("sck_done", {31'b0, spi_sck}, 32'd0);
      check("busy_done", {31'b0, busy}, 32'd1);
      if (hold) addr = next_a;
      else      rd_en = 1'b0;
      step();
      check("one_pulse", {31'b0, ready}, 32'd0);
      check("dout_hold", dout, exp_d);
   endtask

   initial begin
      int rdy_cnt;
      logic [23:0] a;
      // Reset state
      repeat (3) step();
      check("rst_csn", {31'b0, spi_csn}, 32'd1);
      check("rst_sck", {31'b0, spi_sck}, 32'd0);
      check("rst_mosi", {31'b0, spi_mosi}, 32'd0);
      check("rst_ready", {31'b0, ready}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_dout", dout, 32'd0);
      reset = 1'b0;

      // Known-content read
      run_txn(24'h200000, 1'b1, 1'b0, 1'b0, 24'h0);
      check("known_word", dout, 32'h44332211);

      // Back-to-back with rd_en held, address stepping by 2
      a = 24'($urandom);
      for (int k = 0; k < 4; k++)
         run_txn(a + 24'(2 * k), k == 0, k < 3, 1'b0, a + 24'(2 * (k + 1)));

      // Reset during address bit 10
      repeat (CS_GAP + 2) step();
      addr  = 24'h123456;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("rst_mid_start", {31'b0, spi_csn}, 32'd0);
      repeat ((8 + 10) * 2 * CLK_DIV) step();
      reset = 1'b1;
      step();
      check("rst_mid_csn", {31'b0, spi_csn}, 32'd1);
      check("rst_mid_sck", {31'b0, spi_sck}, 32'd0);
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      reset = 1'b0;
      rdy_cnt = 0;
      for (int i = 0; i < 2 * CLK_DIV * NB; i++) begin
         step();
         if (ready === 1'b1) rdy_cnt++;
      end
      check("rst_no_ready", rdy_cnt, 0);
      run_txn(24'h123456, 1'b1, 1'b0, 1'b0, 24'h0);

      // Address change during DATA
      run_txn(24'h3C5A01, 1'b1, 1'b0, 1'b1, 24'h0);

      // Boundaries and random addresses
      run_txn(24'h00FFC0, 1'b1, 1'b0, 1'b0, 24'h0);
      run_txn(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 24'h0);
      run_txn(24'hFFFFFE, 1'b1, 1'b0, 1'b0, 24'h0);
      run_txn(24'h000000, 1'b1, 1'b0, 1'b0, 24'h0);
      for (int k = 0; k < 6; k++)
         run_txn(24'($urandom), 1'b1, 1'b0, 1'b0, 24'h0);

      check("dummy_mosi_low", f_dummy_bad, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
